// File: rtl/mst_pkg.sv
// rtl/mst_pkg.sv - shared word layout and FSM encodings for the master write arbiter
package mst_pkg;

    localparam int MST_W       = 18;
    localparam int MST_EOP_BIT = 17;
    localparam int MST_SOP_BIT = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mst_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first pending index after ptr, wrapping
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] pend,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            vld
);

    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        vld  = 1'b0;
        // ptr itself is searched last, so the previous winner has lowest priority
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!vld && pend[idx]) begin
                pick[idx] = 1'b1;
                vld       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mst_wr_arbiter.sv
// rtl/mst_wr_arbiter.sv - packet-atomic round-robin arbiter for the master write FIFO
// Optional mid-packet stall watchdog enabled by defining MST_ARB_WDOG_EN.
module mst_wr_arbiter
    import mst_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int WDOG_CYC = 1024
) (
    input  logic                  pcie_clk,
    input  logic                  sys_rst_n,
    input  logic [NREQ-1:0]       req_pend,
    output logic [NREQ-1:0]       req_gnt,
    input  logic [NREQ-1:0]       req_wr_en,
    input  logic [NREQ*MST_W-1:0] req_din,
    output logic [NREQ-1:0]       req_full,
    output logic [MST_W-1:0]      mst_din,
    output logic                  mst_wr_en,
    input  logic                  mst_full,
    output logic [15:0]           pkt_cnt,
    output logic                  wdog_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    mst_state_t      state, state_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [PW-1:0]   rr_ptr, ptr_nxt, g_idx;
    logic [NREQ-1:0] pick;
    logic            pick_vld;
    logic            eop_acc;
    logic            cnt_inc;
    logic            wdog_fire;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .pend (req_pend),
        .ptr  (rr_ptr),
        .pick (pick),
        .vld  (pick_vld)
    );

    // Grant is zero outside BUSY, so the mux and strobe need no state gating
    always_comb begin
        mst_din = '0;
        g_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_gnt[i]) begin
                mst_din = req_din[MST_W*i +: MST_W];
                g_idx   = PW'(i);
            end
        end
    end

    assign req_full  = {NREQ{mst_full}} | ~req_gnt;
    assign mst_wr_en = (|(req_wr_en & req_gnt)) & ~mst_full;
    assign eop_acc   = mst_wr_en & mst_din[MST_EOP_BIT];

    always_comb begin
        state_nxt = state;
        gnt_nxt   = req_gnt;
        ptr_nxt   = rr_ptr;
        cnt_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_nxt   = pick;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (eop_acc) begin
                    gnt_nxt   = '0;
                    ptr_nxt   = g_idx;
                    cnt_inc   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wdog_fire) begin
                    gnt_nxt   = '0;
                    ptr_nxt   = g_idx;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            req_gnt <= '0;
            rr_ptr  <= PW'(NREQ - 1);
            pkt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            req_gnt <= gnt_nxt;
            rr_ptr  <= ptr_nxt;
            if (cnt_inc) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

`ifdef MST_ARB_WDOG_EN
    localparam int WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    logic [WW-1:0] wdog_cnt;

    assign wdog_fire = (state == ST_BUSY) && !mst_full && !mst_wr_en
                       && (wdog_cnt == WW'(WDOG_CYC - 1));

    // Held at zero outside BUSY, which also clears it on entry to BUSY
    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            wdog_err <= wdog_fire;
            if (state != ST_BUSY || mst_wr_en || wdog_fire) begin
                wdog_cnt <= '0;
            end else if (!mst_full) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_wdog_cfg;

    assign unused_wdog_cfg = ^WDOG_CYC;
    assign wdog_fire       = 1'b0;
    assign wdog_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mst_wr_arbiter.sv
// tb/tb_mst_wr_arbiter.sv - directed self-checking bench for mst_wr_arbiter
module tb_mst_wr_arbiter;

    logic        pcie_clk = 1'b0;
    logic        sys_rst_n;
    logic [1:0]  req_pend;
    logic [1:0]  req_gnt;
    logic [1:0]  req_wr_en;
    logic [35:0] req_din;
    logic [1:0]  req_full;
    logic [17:0] mst_din;
    logic        mst_wr_en;
    logic        mst_full;
    logic [15:0] pkt_cnt;
    logic        wdog_err;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [17:0] wr_log[$];
    logic [17:0] t1w[3] = '{18'h1_0011, 18'h0_0022, 18'h2_0033};

    mst_wr_arbiter #(
        .NREQ     (2),
        .WDOG_CYC (16)
    ) dut (
        .pcie_clk  (pcie_clk),
        .sys_rst_n (sys_rst_n),
        .req_pend  (req_pend),
        .req_gnt   (req_gnt),
        .req_wr_en (req_wr_en),
        .req_din   (req_din),
        .req_full  (req_full),
        .mst_din   (mst_din),
        .mst_wr_en (mst_wr_en),
        .mst_full  (mst_full),
        .pkt_cnt   (pkt_cnt),
        .wdog_err  (wdog_err)
    );

    always #5 pcie_clk = ~pcie_clk;

    always @(posedge pcie_clk) begin
        if (mst_wr_en) wr_log.push_back(mst_din);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge pcie_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_pend  = '0;
        req_wr_en = '0;
        req_din   = '0;
        mst_full  = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        wr_log.delete();
    endtask

    task automatic drive(input int r, input logic [17:0] w);
        req_wr_en = '0;
        req_din   = '0;
        req_wr_en[r] = 1'b1;
        req_din[18*r +: 18] = w;
    endtask

    initial begin
        // 1: single 3-word packet from req0
        do_reset();
        settle();
        chk("rst_gnt", req_gnt, 32'h0);
        chk("rst_pkt_cnt", pkt_cnt, 32'h0);
        chk("rst_wdog", wdog_err, 32'h0);
        chk("rst_full", req_full, 32'h3);
        chk("rst_wr_en", mst_wr_en, 32'h0);
        req_pend = 2'b01;
        settle();
        chk("t1_gnt_not_comb", req_gnt, 32'h0);
        tick();
        chk("t1_gnt", req_gnt, 32'h1);
        req_pend = 2'b00;
        for (int k = 0; k < 3; k++) begin
            drive(0, t1w[k]);
            settle();
            chk("t1_wr_en", mst_wr_en, 32'h1);
            chk("t1_din", mst_din, 32'(t1w[k]));
            chk("t1_gnt_hold", req_gnt, 32'h1);
            tick();
        end
        req_wr_en = '0;
        chk("t1_gnt_rel", req_gnt, 32'h0);
        chk("t1_pkt_cnt", pkt_cnt, 32'h1);
        chk("t1_nwords", wr_log.size(), 32'd3);
        if (wr_log.size() == 3) chk("t1_last_word", wr_log[2], 32'h2_0033);

        // 2: both pending, 1-word packets alternate with a bubble
        do_reset();
        req_pend = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            req_wr_en = '0;
            chk("t2_gnt", req_gnt, (k % 2 == 0) ? 32'h1 : 32'h2);
            drive((k % 2 == 0) ? 0 : 1, 18'h3_0000 | 18'(k));
            settle();
            chk("t2_wr_en", mst_wr_en, 32'h1);
            chk("t2_din", mst_din, 32'h3_0000 | 32'(k));
            tick();
            chk("t2_bubble", req_gnt, 32'h0);
            chk("t2_pkt_cnt", pkt_cnt, 32'(k + 1));
        end
        req_wr_en = '0;
        req_pend  = '0;

        // 3: non-granted requester strobes
        do_reset();
        req_pend = 2'b10;
        tick();
        chk("t3_gnt", req_gnt, 32'h2);
        req_wr_en = 2'b01;
        req_din   = {18'h0_0055, 18'h3_ffff};
        settle();
        chk("t3_no_wr", mst_wr_en, 32'h0);
        chk("t3_din_req1", mst_din, 32'h0_0055);
        chk("t3_full", req_full, 32'h1);
        tick();
        chk("t3_gnt_hold", req_gnt, 32'h2);
        req_wr_en = 2'b11;
        req_din   = {18'h2_0066, 18'h3_ffff};
        settle();
        chk("t3_wr_req1", mst_wr_en, 32'h1);
        chk("t3_din_eop", mst_din, 32'h2_0066);
        tick();
        req_wr_en = '0;
        chk("t3_gnt_rel", req_gnt, 32'h0);
        chk("t3_pkt_cnt", pkt_cnt, 32'h1);
        chk("t3_nwords", wr_log.size(), 32'd1);

        // 4: back-pressure mid-packet
        do_reset();
        req_pend = 2'b01;
        tick();
        chk("t4_gnt", req_gnt, 32'h1);
        drive(0, 18'h1_00a1);
        tick();
        mst_full = 1'b1;
        drive(0, 18'h0_00b2);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t4_stall_no_wr", mst_wr_en, 32'h0);
            chk("t4_stall_full", req_full, 32'h3);
            tick();
        end
        mst_full = 1'b0;
        settle();
        chk("t4_resume_wr", mst_wr_en, 32'h1);
        chk("t4_resume_din", mst_din, 32'h0_00b2);
        tick();
        drive(0, 18'h2_00c3);
        tick();
        req_wr_en = '0;
        req_pend  = '0;
        chk("t4_gnt_rel", req_gnt, 32'h0);
        chk("t4_nwords", wr_log.size(), 32'd3);
        if (wr_log.size() == 3) begin
            chk("t4_w0", wr_log[0], 32'h1_00a1);
            chk("t4_w1", wr_log[1], 32'h0_00b2);
            chk("t4_w2", wr_log[2], 32'h2_00c3);
        end

`ifdef MST_ARB_WDOG_EN
        // 5: watchdog forced release after 16 idle-stall cycles
        do_reset();
        req_pend = 2'b11;
        tick();
        chk("t5_gnt0", req_gnt, 32'h1);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("t5_hold", req_gnt, 32'h1);
            chk("t5_no_err", wdog_err, 32'h0);
        end
        tick();
        chk("t5_err", wdog_err, 32'h1);
        chk("t5_rel", req_gnt, 32'h0);
        chk("t5_pkt_cnt", pkt_cnt, 32'h0);
        tick();
        chk("t5_err_pulse", wdog_err, 32'h0);
        chk("t5_gnt1", req_gnt, 32'h2);
`else
        // 5: without the watchdog a stalled grant is held
        do_reset();
        req_pend = 2'b01;
        tick();
        req_pend = 2'b10;
        repeat (40) tick();
        chk("t5_hold", req_gnt, 32'h1);
        chk("t5_no_err", wdog_err, 32'h0);
`endif

        // 6: async reset mid-packet
        do_reset();
        req_pend = 2'b10;
        tick();
        chk("t6_gnt", req_gnt, 32'h2);
        drive(1, 18'h1_0077);
        tick();
        req_wr_en = '0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t6_async_drop", req_gnt, 32'h0);
        tick();
        sys_rst_n = 1'b1;
        req_pend  = 2'b11;
        tick();
        chk("t6_req0_first", req_gnt, 32'h1);
        chk("t6_pkt_cnt", pkt_cnt, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
